// File: rtl/counter_cascade_monitor_pkg.sv
// Shared encodings and default widths for the counter cascade monitor.
// Mode values mirror the upstream 4-bit counter's mode input.
package counter_cascade_monitor_pkg;

    typedef enum logic [1:0] {
        MODE_UP0  = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_UP1  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } meter_state_e;

    localparam int unsigned DEFAULT_PERIOD_W = 8;
    localparam int unsigned DEFAULT_HI_W     = 12;

endpackage

// File: rtl/counter_cascade_monitor_period_meter.sv
// Measures cycles between rco pulses and holds one result for a
// valid/ready consumer, flagging saturation and dropped measurements.
module period_meter
    import counter_cascade_monitor_pkg::*;
#(
    parameter int unsigned PERIOD_W = DEFAULT_PERIOD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rco,
    input  logic                load,
    input  logic                period_ready,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                timeout,
    output logic                overflow
);

    meter_state_e        state;
    logic [PERIOD_W-1:0] count;
    logic                emit;

    assign emit = (state == ARMED) && rco && !load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (load) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rco) begin
                            state <= ARMED;
                            count <= PERIOD_W'(1);
                        end
                    end
                    ARMED: begin
                        if (rco) begin
                            count <= PERIOD_W'(1);
                        end else if (&count[PERIOD_W-1:1]) begin
                            // count is max-1 or max: pin at max and flag
                            count   <= '1;
                            timeout <= 1'b1;
                        end else begin
                            count <= count + PERIOD_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end

            if (emit && (!period_valid || period_ready)) begin
                period       <= count;
                period_valid <= 1'b1;
            end else if (emit) begin
                overflow <= 1'b1;
            end else if (period_valid && period_ready) begin
                period_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/counter_cascade_monitor.sv
// Extends the 4-bit counter into a registered 16-bit cascaded count and
// reports the interval between ripple-carry pulses.
module counter_cascade_monitor
    import counter_cascade_monitor_pkg::*;
#(
    parameter int unsigned PERIOD_W = DEFAULT_PERIOD_W,
    parameter int unsigned HI_W     = DEFAULT_HI_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic                rco,
    input  logic                load,
    input  logic [3:0]          Q,
    output logic [HI_W+3:0]     Q_ext,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    input  logic                period_ready,
    output logic                timeout,
    output logic                overflow
);

    mode_e           mode_s;
    logic [HI_W-1:0] hi;
    logic [HI_W-1:0] hi_next;

    assign mode_s = mode_e'(mode);
    // The high part lives only in Q_ext; a separate hi register would be a copy.
    assign hi     = Q_ext[HI_W+3:4];

    always_comb begin
        hi_next = hi;
        if (load || (mode_s == MODE_LOAD)) begin
            hi_next = '0;
        end else if (enable && rco) begin
            hi_next = (mode_s == MODE_DOWN) ? hi - HI_W'(1) : hi + HI_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q_ext <= '0;
        end else begin
            Q_ext <= {hi_next, Q};
        end
    end

    period_meter #(
        .PERIOD_W (PERIOD_W)
    ) u_period_meter (
        .clk          (clk),
        .reset        (reset),
        .rco          (rco),
        .load         (load),
        .period_ready (period_ready),
        .period       (period),
        .period_valid (period_valid),
        .timeout      (timeout),
        .overflow     (overflow)
    );

endmodule

// File: tb/tb_counter_cascade_monitor.sv
// Directed bench for counter_cascade_monitor: a single-cycle vector table
// followed by multi-cycle sequences for wrap, interval, overflow, timeout, reset.
module tb_counter_cascade_monitor;

    localparam int unsigned PERIOD_W = 8;
    localparam int unsigned HI_W     = 12;

    logic                clk;
    logic                reset;
    logic                enable;
    logic [1:0]          mode;
    logic                rco;
    logic                load;
    logic [3:0]          Q;
    logic [HI_W+3:0]     Q_ext;
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic                period_ready;
    logic                timeout;
    logic                overflow;

    int checks = 0;
    int errors = 0;

    counter_cascade_monitor #(
        .PERIOD_W (PERIOD_W),
        .HI_W     (HI_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .mode         (mode),
        .rco          (rco),
        .load         (load),
        .Q            (Q),
        .Q_ext        (Q_ext),
        .period       (period),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .timeout      (timeout),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  md;
        logic        r;
        logic        ld;
        logic [3:0]  q;
        logic        rdy;
        logic [15:0] e_qext;
        logic [7:0]  e_period;
        logic        e_valid;
        logic        e_to;
        logic        e_ov;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic en_v, input logic [1:0] md_v, input logic r_v,
                        input logic ld_v, input logic [3:0] q_v, input logic rdy_v);
        @(negedge clk);
        enable       = en_v;
        mode         = md_v;
        rco          = r_v;
        load         = ld_v;
        Q            = q_v;
        period_ready = rdy_v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n, input logic rdy_v);
        for (int unsigned i = 0; i < n; i++) tick(1'b1, 2'b10, 1'b0, 1'b0, 4'h0, rdy_v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0; mode = 2'b00; rco = 1'b0; load = 1'b0; Q = 4'h0; period_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_qext"},    32'(Q_ext), 32'h0);
        check({tag, "_period"},  32'(period), 32'h0);
        check({tag, "_valid"},   32'(period_valid), 32'h0);
        check({tag, "_timeout"}, 32'(timeout), 32'h0);
        check({tag, "_ovf"},     32'(overflow), 32'h0);
    endtask

    initial begin
        //           en  md    rco ld  q     rdy  Q_ext     per  v  to ov
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 1'b0, 4'h3, 1'b0, 16'h0003, 8'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b10, 1'b1, 1'b0, 4'h4, 1'b0, 16'h0014, 8'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'b10, 1'b1, 1'b0, 4'h5, 1'b0, 16'h0025, 8'd1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 2'b10, 1'b1, 1'b0, 4'h6, 1'b0, 16'h0026, 8'd1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 2'b01, 1'b1, 1'b0, 4'h7, 1'b1, 16'h0017, 8'd1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 2'b01, 1'b0, 1'b0, 4'h8, 1'b1, 16'h0018, 8'd1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 2'b00, 1'b1, 1'b1, 4'h9, 1'b0, 16'h0009, 8'd1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 2'b11, 1'b1, 1'b0, 4'hA, 1'b0, 16'h000A, 8'd1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 2'b01, 1'b1, 1'b0, 4'hF, 1'b0, 16'hFFFF, 8'd1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 2'b10, 1'b1, 1'b0, 4'h0, 1'b1, 16'h0000, 8'd1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 1'b0, 4'h1, 1'b1, 16'h0001, 8'd1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 2'b10, 1'b0, 1'b0, 4'h2, 1'b1, 16'h0002, 8'd1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 2'b10, 1'b1, 1'b0, 4'h3, 1'b0, 16'h0013, 8'd3, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 2'b10, 1'b0, 1'b1, 4'h4, 1'b0, 16'h0004, 8'd3, 1'b1, 1'b0, 1'b1};

        reset = 1'b0;
        enable = 1'b0; mode = 2'b00; rco = 1'b0; load = 1'b0; Q = 4'h0; period_ready = 1'b0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            tick(vecs[i].en, vecs[i].md, vecs[i].r, vecs[i].ld, vecs[i].q, vecs[i].rdy);
            check($sformatf("v%0d_qext", i),   32'(Q_ext),        32'(vecs[i].e_qext));
            check($sformatf("v%0d_period", i), 32'(period),       32'(vecs[i].e_period));
            check($sformatf("v%0d_valid", i),  32'(period_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d_to", i),     32'(timeout),      32'(vecs[i].e_to));
            check($sformatf("v%0d_ovf", i),    32'(overflow),     32'(vecs[i].e_ov));
        end

        // 16 back-to-back rco pulses counting up
        do_reset();
        for (int i = 0; i < 16; i++) tick(1'b1, 2'b10, 1'b1, 1'b0, 4'(i), 1'b1);
        check("up16_hi",     32'(Q_ext[15:4]), 32'h010);
        check("up16_period", 32'(period), 32'd1);

        // wrap down then load clears hi and disarms the meter
        do_reset();
        tick(1'b1, 2'b01, 1'b1, 1'b0, 4'h5, 1'b0);
        check("down_wrap_hi", 32'(Q_ext[15:4]), 32'hFFF);
        tick(1'b1, 2'b01, 1'b0, 1'b1, 4'h5, 1'b0);
        check("load_hi", 32'(Q_ext[15:4]), 32'h000);
        tick(1'b1, 2'b10, 1'b1, 1'b0, 4'h0, 1'b0);
        check("load_idle_noemit", 32'(period_valid), 32'h0);
        tick(1'b1, 2'b10, 1'b1, 1'b0, 4'h0, 1'b0);
        check("rearm_period", 32'(period), 32'd1);
        check("rearm_valid",  32'(period_valid), 32'h1);

        // rco every 16 cycles, consumer always ready
        do_reset();
        for (int p = 0; p < 3; p++) begin
            tick(1'b1, 2'b10, 1'b1, 1'b0, 4'h0, 1'b1);
            if (p > 0) begin
                check($sformatf("p16_%0d_period", p), 32'(period), 32'd16);
                check($sformatf("p16_%0d_valid", p),  32'(period_valid), 32'h1);
            end
            idle(1, 1'b1);
            check($sformatf("p16_%0d_drop", p), 32'(period_valid), 32'h0);
            idle(14, 1'b1);
        end

        // consumer stalled, pulses 5 cycles apart
        do_reset();
        for (int p = 0; p < 3; p++) begin
            tick(1'b1, 2'b10, 1'b1, 1'b0, 4'h0, 1'b0);
            if (p == 1) check("ovf_before", 32'(overflow), 32'h0);
            if (p < 2) idle(4, 1'b0);
        end
        check("ovf_period", 32'(period), 32'd5);
        check("ovf_valid",  32'(period_valid), 32'h1);
        check("ovf_flag",   32'(overflow), 32'h1);

        // interval saturation
        do_reset();
        tick(1'b1, 2'b10, 1'b1, 1'b0, 4'h0, 1'b0);
        idle(253, 1'b0);
        check("to_before", 32'(timeout), 32'h0);
        idle(1, 1'b0);
        check("to_at_sat", 32'(timeout), 32'h1);
        idle(46, 1'b0);
        tick(1'b1, 2'b10, 1'b1, 1'b0, 4'h0, 1'b0);
        check("to_period", 32'(period), 32'd255);
        check("to_valid",  32'(period_valid), 32'h1);
        check("to_sticky", 32'(timeout), 32'h1);

        // asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async");
        @(negedge clk);
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
